// File: rtl/oh_pads_ctrl.sv
// Core-side controller for one padring IO domain: software register file,
// power-up sequencer for oen/ie, and a synchronised din path with sticky edge flags.
module oh_pads_ctrl #(
  parameter int NGPIO  = 8,
  parameter int SETTLE = 16,
  parameter int AW     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [AW-1:0]      reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               active,
  output logic [NGPIO-1:0]   dout,
  output logic [NGPIO-1:0]   oen,
  output logic [NGPIO-1:0]   ie,
  output logic [NGPIO*8-1:0] cfg,
  input  logic [NGPIO-1:0]   din
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {OFF, WAIT, INEN, RUN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               ctrl_en;
  logic [NGPIO-1:0]   oen_sh;
  logic [NGPIO-1:0]   ie_sh;
  logic [NGPIO-1:0]   din_s1;
  logic [NGPIO-1:0]   din_s2;
  logic [NGPIO-1:0]   din_s3;
  logic [NGPIO-1:0]   rise;
  logic [NGPIO-1:0]   fall;

  logic               ctrl_nx;
  logic [NGPIO-1:0]   dout_nx;
  logic [NGPIO-1:0]   oen_nx;
  logic [NGPIO-1:0]   ie_nx;
  logic [NGPIO*8-1:0] cfg_nx;
  logic [NGPIO-1:0]   rise_nx;
  logic [NGPIO-1:0]   fall_nx;
  logic [NGPIO-1:0]   wmask;
  logic [AW-1:0]      cfg_idx;
  logic               cfg_hit;
  logic [31:0]        rd_val;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata;
  assign wmask        = reg_wdata[NGPIO-1:0];
  assign cfg_idx      = reg_addr - AW'(8);
  assign cfg_hit      = (reg_addr >= AW'(8)) && (cfg_idx < AW'(NGPIO));

  // Next-state of the software-visible registers; pins register these directly
  // so a write lands on the pads one edge after the strobe.
  always_comb begin
    ctrl_nx = ctrl_en;
    dout_nx = dout;
    oen_nx  = oen_sh;
    ie_nx   = ie_sh;
    cfg_nx  = cfg;
    if (reg_wr) begin
      case (reg_addr)
        AW'(0):  ctrl_nx = reg_wdata[0];
        AW'(1):  dout_nx = wmask;
        AW'(2):  oen_nx  = wmask;
        AW'(3):  ie_nx   = wmask;
        default: begin
          for (int i = 0; i < NGPIO; i++) begin
            if (cfg_hit && (cfg_idx == AW'(i))) begin
              cfg_nx[i*8 +: 8] = reg_wdata[7:0];
            end else begin
              cfg_nx[i*8 +: 8] = cfg[i*8 +: 8];
            end
          end
        end
      endcase
    end else begin
      ctrl_nx = ctrl_en;
    end
  end

  // Sticky edge flags: only armed while the pad input is enabled; a new edge
  // beats a simultaneous write-one-to-clear.
  always_comb begin
    rise_nx = rise & ~((reg_wr && reg_addr == AW'(5)) ? wmask : {NGPIO{1'b0}});
    fall_nx = fall & ~((reg_wr && reg_addr == AW'(6)) ? wmask : {NGPIO{1'b0}});
    rise_nx = rise_nx | (din_s2 & ~din_s3 & ie);
    fall_nx = fall_nx | (~din_s2 & din_s3 & ie);
  end

  // Read mux over current register contents.
  always_comb begin
    rd_val = 32'd0;
    case (reg_addr)
      AW'(0):  rd_val[0] = ctrl_en;
      AW'(1):  rd_val[NGPIO-1:0] = dout;
      AW'(2):  rd_val[NGPIO-1:0] = oen_sh;
      AW'(3):  rd_val[NGPIO-1:0] = ie_sh;
      AW'(4):  rd_val[NGPIO-1:0] = din_s2;
      AW'(5):  rd_val[NGPIO-1:0] = rise;
      AW'(6):  rd_val[NGPIO-1:0] = fall;
      default: begin
        for (int i = 0; i < NGPIO; i++) begin
          if (cfg_hit && (cfg_idx == AW'(i))) begin
            rd_val[7:0] = cfg[i*8 +: 8];
          end else begin
            rd_val[31:8] = 24'd0;
          end
        end
      end
    endcase
  end

  // Register file, din synchroniser and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      dout      <= {NGPIO{1'b0}};
      oen_sh    <= {NGPIO{1'b1}};
      ie_sh     <= {NGPIO{1'b0}};
      cfg       <= {(NGPIO*8){1'b0}};
      din_s1    <= {NGPIO{1'b0}};
      din_s2    <= {NGPIO{1'b0}};
      din_s3    <= {NGPIO{1'b0}};
      rise      <= {NGPIO{1'b0}};
      fall      <= {NGPIO{1'b0}};
      reg_rdata <= 32'd0;
    end else begin
      ctrl_en <= ctrl_nx;
      dout    <= dout_nx;
      oen_sh  <= oen_nx;
      ie_sh   <= ie_nx;
      cfg     <= cfg_nx;
      din_s1  <= din;
      din_s2  <= din_s1;
      din_s3  <= din_s2;
      rise    <= rise_nx;
      fall    <= fall_nx;
      if (reg_rd) begin
        reg_rdata <= rd_val;
      end
    end
  end

  // Power-up sequencer; uses next-cycle enable so a disable tristates on the
  // same edge that the CTRL write lands.
  always_ff @(posedge clk) begin
    if (reset || !ctrl_nx) begin
      state  <= OFF;
      cnt    <= {CW{1'b0}};
      oen    <= {NGPIO{1'b1}};
      ie     <= {NGPIO{1'b0}};
      active <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          state  <= WAIT;
          cnt    <= {CW{1'b0}};
          oen    <= {NGPIO{1'b1}};
          ie     <= {NGPIO{1'b0}};
          active <= 1'b0;
        end
        WAIT: begin
          oen    <= {NGPIO{1'b1}};
          active <= 1'b0;
          if (cnt == CW'(SETTLE - 1)) begin
            state <= INEN;
            ie    <= ie_nx;
          end else begin
            cnt <= cnt + CW'(1);
            ie  <= {NGPIO{1'b0}};
          end
        end
        INEN, RUN: begin
          state  <= RUN;
          oen    <= oen_nx;
          ie     <= ie_nx;
          active <= 1'b1;
        end
        default: begin
          state  <= OFF;
          oen    <= {NGPIO{1'b1}};
          ie     <= {NGPIO{1'b0}};
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
